// File: rtl/mc_sequencer_if.sv
// +------------------------------------------------------------------+
// | mc_sequencer_if : CPU/decoder/execution-unit bus of mc_sequencer |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

interface mc_sequencer_if;
   logic       run;
   logic       instr_valid;
   logic [7:0] instr;
   logic       exec_done;
   logic [7:0] exec_result;
   logic       exec_start;
   logic [3:0] exec_op;
   logic [1:0] exec_sel_a;
   logic [1:0] exec_sel_b;
   logic       cpu_stall;
   logic [7:0] result;
   logic       result_valid;
   logic       next_instruction_trigger;
   logic       illegal_op;
   logic       timeout;

   modport master (
      output run, instr_valid, instr, exec_done, exec_result,
      input  exec_start, exec_op, exec_sel_a, exec_sel_b, cpu_stall,
             result, result_valid, next_instruction_trigger, illegal_op, timeout
   );

   modport slave (
      input  run, instr_valid, instr, exec_done, exec_result,
      output exec_start, exec_op, exec_sel_a, exec_sel_b, cpu_stall,
             result, result_valid, next_instruction_trigger, illegal_op, timeout
   );
endinterface

`default_nettype wire

// File: rtl/mc_sequencer.sv
// +------------------------------------------------------------------+
// | mc_sequencer : multicycle-instruction issue/wait/writeback FSM   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module mc_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic           clock,
   input  logic           reset,
   mc_sequencer_if.slave  bus
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_WB    = 2'd3;

   // WAIT lasts TIMEOUT_CYCLES run-high cycles: the counter walks 0..TIMEOUT_CYCLES-1
   // and the abort happens on the run-high edge that finds it at the terminal value.
   localparam logic [7:0] c_TERM_CNT = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] op_q, op_d;
   logic [1:0] sel_a_q, sel_a_d;
   logic [1:0] sel_b_q, sel_b_d;
   logic [7:0] result_q, result_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;
   logic       w_legal;

   assign w_legal = (bus.instr[7:4] >= 4'h1) && (bus.instr[7:4] <= 4'h5);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      sel_a_d   = sel_a_q;
      sel_b_d   = sel_b_q;
      result_d  = result_q;
      illegal_d = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (bus.run && bus.instr_valid) begin
               if (w_legal) begin
                  op_d    = bus.instr[7:4];
                  sel_a_d = bus.instr[3:2];
                  sel_b_d = bus.instr[1:0];
                  state_d = c_ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         c_ISSUE: begin
            cnt_d   = 8'd0;
            state_d = c_WAIT;
         end
         c_WAIT: begin
            // Completion wins over a coincident terminal count, and is taken even with run low.
            if (bus.exec_done) begin
               result_d = bus.exec_result;
               state_d  = c_WB;
            end else if (bus.run) begin
               if (cnt_q == c_TERM_CNT) begin
                  result_d  = 8'h00;
                  timeout_d = 1'b1;
                  state_d   = c_WB;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= c_IDLE;
         cnt_q     <= 8'd0;
         op_q      <= 4'd0;
         sel_a_q   <= 2'd0;
         sel_b_q   <= 2'd0;
         result_q  <= 8'h00;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         sel_a_q   <= sel_a_d;
         sel_b_q   <= sel_b_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.exec_start               = (state_q == c_ISSUE);
   assign bus.cpu_stall                = (state_q != c_IDLE);
   assign bus.result_valid             = (state_q == c_WB);
   assign bus.next_instruction_trigger = (state_q == c_WB) || illegal_q;
   assign bus.illegal_op               = illegal_q;
   assign bus.timeout                  = timeout_q;
   assign bus.exec_op                  = op_q;
   assign bus.exec_sel_a               = sel_a_q;
   assign bus.exec_sel_b               = sel_b_q;
   assign bus.result                   = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_sequencer.sv
// +------------------------------------------------------------------+
// | tb_mc_sequencer : self-checking bench for mc_sequencer           |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mc_sequencer;

   localparam int T = 8;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] exp_result;
   logic [7:0] exp_opsel;

   mc_sequencer_if bus ();

   mc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.run         = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 8'h00;
      bus.exec_done   = 1'b0;
      bus.exec_result = 8'h00;
   endtask

   function automatic logic [5:0] flags();
      return {bus.exec_start, bus.cpu_stall, bus.result_valid,
              bus.next_instruction_trigger, bus.illegal_op, bus.timeout};
   endfunction

   // Timeline model: cycle 0 presents the instruction; exec_done pulses in cycle d;
   // run is low in cycles [rs, rs+rl). WAIT begins in cycle 2 and aborts on its
   // T-th run-high cycle; done counts only when it lands in WAIT.
   task automatic test_op(input string name, input logic [7:0] ins, input int d,
                          input logic [7:0] dres, input int rs, input int rl);
      int   t, e, n, last;
      logic tmo, legal, runb;
      logic [5:0] want;
      legal = (ins[7:4] >= 4'h1) && (ins[7:4] <= 4'h5);
      e = 0; tmo = 1'b0;
      if (legal) begin
         n = 0; t = 1;
         while (n < T) begin
            t++;
            if (!(t >= rs && t < rs + rl)) n++;
         end
         if (d >= 2 && d <= t) begin e = d; tmo = 1'b0; end
         else begin e = t; tmo = 1'b1; end
         last = e + 2;
      end else begin
         last = 2;
      end
      if (d > last) last = d;
      for (int c = 0; c <= last; c++) begin
         runb            = !(c >= rs && c < rs + rl);
         bus.run         = runb;
         bus.instr_valid = (c == 0) || (legal && c >= 1 && c <= e + 1 && ($urandom_range(0, 1) == 1));
         bus.instr       = (c == 0) ? ins : 8'($urandom);
         bus.exec_done   = (c == d);
         bus.exec_result = (c == d) ? dres : 8'($urandom);
         if (legal) begin
            want = {c == 1, c >= 1 && c <= e + 1, c == e + 1, c == e + 1, 1'b0, tmo && c == e + 1};
            if (c == 1) exp_opsel = ins;
            if (c == e + 1) exp_result = tmo ? 8'h00 : dres;
         end else begin
            want = {1'b0, 1'b0, 1'b0, c == 1, c == 1, 1'b0};
         end
         total++;
         if (flags() !== want) begin
            bad++;
            $display("FAIL %s flags cyc=%0d got=%b want=%b (start,stall,rv,trig,ill,tmo)",
                     name, c, flags(), want);
         end
         total++;
         if ({bus.result, bus.exec_op, bus.exec_sel_a, bus.exec_sel_b} !== {exp_result, exp_opsel}) begin
            bad++;
            $display("FAIL %s data cyc=%0d got result=%h opsel=%h want result=%h opsel=%h",
                     name, c, bus.result, {bus.exec_op, bus.exec_sel_a, bus.exec_sel_b},
                     exp_result, exp_opsel);
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      exp_result = 8'h00;
      exp_opsel  = 8'h00;
      step();
      total++;
      if ({flags(), bus.result, bus.exec_op, bus.exec_sel_a, bus.exec_sel_b} !== 22'd0) begin
         bad++;
         $display("FAIL reset_state got flags=%b result=%h want all zero", flags(), bus.result);
      end
      step();
      reset = 1'b0;
      step();
      total++;
      if ({flags(), bus.result} !== 14'd0) begin
         bad++;
         $display("FAIL reset_release got flags=%b result=%h want all zero", flags(), bus.result);
      end
   endtask

   task automatic test_run_low_idle();
      bus.run         = 1'b0;
      bus.instr_valid = 1'b1;
      bus.instr       = 8'h2B;
      for (int c = 0; c < 4; c++) begin
         step();
         total++;
         if (flags() !== 6'd0) begin
            bad++;
            $display("FAIL run_low_idle cyc=%0d got=%b want=000000", c, flags());
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_op();
      bus.instr_valid = 1'b1;
      bus.instr       = 8'h33;
      step();
      bus.instr_valid = 1'b0;
      step();
      step();
      #2 reset = 1'b1;
      #1;
      exp_result = 8'h00;
      exp_opsel  = 8'h00;
      total++;
      if ({flags(), bus.result, bus.exec_op, bus.exec_sel_a, bus.exec_sel_b} !== 22'd0) begin
         bad++;
         $display("FAIL reset_mid_op got flags=%b result=%h opsel=%h want all zero",
                  flags(), bus.result, {bus.exec_op, bus.exec_sel_a, bus.exec_sel_b});
      end
      step();
      reset = 1'b0;
      step();
      bus.exec_done   = 1'b1;
      bus.exec_result = 8'hAA;
      step();
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({flags(), bus.result, bus.exec_op} !== 18'd0) begin
            bad++;
            $display("FAIL late_done cyc=%0d got flags=%b result=%h want zero", c, flags(), bus.result);
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [7:0] ins;
      int d;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 9) < 7) ins = {4'($urandom_range(1, 5)), 4'($urandom)};
         else ins = {4'($urandom_range(6, 16) & 15), 4'($urandom)};
         d = int'($urandom_range(0, 14)) - 1;
         test_op("random", ins, d, 8'($urandom), int'($urandom_range(2, 10)), int'($urandom_range(0, 5)));
      end
   endtask

   initial begin
      test_reset();
      test_op("basic_2B", 8'h2B, 5, 8'h1E, 100, 0);
      test_op("illegal_9F", 8'h9F, -1, 8'h00, 100, 0);
      test_op("timeout_15", 8'h15, -1, 8'h00, 100, 0);
      test_op("run_pause", 8'h15, -1, 8'h00, 3, 5);
      test_op("done_run_low", 8'h4C, 4, 8'h5A, 3, 5);
      test_op("done_at_terminal", 8'h31, 9, 8'hC3, 100, 0);
      test_op("done_in_issue", 8'h52, 1, 8'h77, 100, 0);
      test_op("illegal_00", 8'h00, 1, 8'h11, 100, 0);
      test_run_low_idle();
      test_reset_mid_op();
      test_op("after_reset", 8'h2B, 3, 8'h64, 100, 0);
      test_op("back_to_back", 8'h16, 2, 8'h99, 100, 0);
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
